// File: rtl/prover_compute_h_ctrl.sv
// prover_compute_h_ctrl: steps H(gamma) element multiplies
// over all (round, point) pairs, one accepted tau per product.
//
// Ports:
//   clk, rst          clock, sync active-high reset
//   start             begin an evaluation (IDLE only)
//   tau_in/valid/ready  upstream tau handshake
//   elem_restart      round-0 multiplicand select level
//   elem_en           one-cycle multiply start
//   elem_done         last point of the current round
//   elem_tau          registered tau
//   elem_m_tau_p1     registered (1 - tau) mod p
//   elem_ready_pulse  per-element multiply-complete pulses
//   h_valid           results valid, capture into v_q
//   round_idx         current bit round
//   point_idx         current point
//   busy              not idle
//   done_pulse        pulse after the final h_valid

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_PRIME
`define F_PRIME 61'h1fff_ffff_ffff_ffff
`endif

module prover_compute_h_ctrl #(
  parameter int nidbits = 3,
  parameter int npoints = 3,
  parameter int nelem   = 8,
  localparam int RW = (nidbits > 1) ? $clog2(nidbits) : 1,
  localparam int PW = (npoints > 1) ? $clog2(npoints) : 1,
  localparam int FN = `F_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FN-1:0]    tau_in,
  input  logic             tau_valid,
  output logic             tau_ready,
  output logic             elem_restart,
  output logic             elem_en,
  output logic             elem_done,
  output logic [FN-1:0]    elem_tau,
  output logic [FN-1:0]    elem_m_tau_p1,
  input  logic [nelem-1:0] elem_ready_pulse,
  output logic             h_valid,
  output logic [RW-1:0]    round_idx,
  output logic [PW-1:0]    point_idx,
  output logic             busy,
  output logic             done_pulse
);

  localparam logic [FN-1:0] PRIME = FN'(`F_PRIME);
  localparam logic [RW-1:0] RLAST = RW'(nidbits - 1);
  localparam logic [PW-1:0] PLAST = PW'(npoints - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_TAU = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_MUL = 3'd3;
  localparam logic [2:0] NEXT     = 3'd4;

  logic [2:0]       state;
  logic [nelem-1:0] collect;
  logic [nelem-1:0] collect_nxt;
  logic [FN-1:0]    m_tau;
  logic             last_point;
  logic             last_round;

  assign last_point  = (point_idx == PLAST);
  assign last_round  = (round_idx == RLAST);
  assign collect_nxt = collect | elem_ready_pulse;

  // p + 1 - tau overflows for tau==0 and is p (not 0)
  // for tau==1, so both ends are pinned explicitly.
  always_comb begin
    m_tau = PRIME - tau_in + FN'(1);
    unique case (1'b1)
      (tau_in == '0):     m_tau = FN'(1);
      (tau_in == FN'(1)): m_tau = '0;
      default:            m_tau = PRIME - tau_in + FN'(1);
    endcase
  end

  assign busy      = (state != IDLE);
  assign tau_ready = (state == WAIT_TAU);
  assign elem_en   = (state == ISSUE);
  assign h_valid   = (state == NEXT);
  assign elem_done = ((state == ISSUE) || (state == WAIT_MUL))
                     && last_point;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      elem_restart  <= 1'b0;
      elem_tau      <= '0;
      elem_m_tau_p1 <= '0;
      round_idx     <= '0;
      point_idx     <= '0;
      collect       <= '0;
      done_pulse    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          // done_pulse is seen in the first idle cycle;
          // a start there belongs to the finished run.
          if (start && !done_pulse) begin
            state        <= WAIT_TAU;
            elem_restart <= 1'b1;
            round_idx    <= '0;
            point_idx    <= '0;
          end
        end
        WAIT_TAU: begin
          if (tau_valid) begin
            elem_tau      <= tau_in;
            elem_m_tau_p1 <= m_tau;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          collect <= '0;
          state   <= WAIT_MUL;
        end
        WAIT_MUL: begin
          collect <= collect_nxt;
          if (&collect_nxt) state <= NEXT;
        end
        NEXT: begin
          state <= WAIT_TAU;
          if (!last_point) begin
            point_idx <= point_idx + PW'(1);
          end else if (!last_round) begin
            point_idx    <= '0;
            round_idx    <= round_idx + RW'(1);
            elem_restart <= 1'b0;
          end else begin
            done_pulse   <= 1'b1;
            elem_restart <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
